// File: rtl/axi_write_sequencer_if.sv
// Bundle of the per-requester AW/W slave ports and the shared AW/W master
// port used by axi_write_sequencer.
//   s_aw_*  : per-requester AW payload/valid/ready (port p at [p*AwWidth +: AwWidth])
//   s_w_*   : per-requester W payload/last/valid/ready
//   m_aw_*  : AW channel to memory
//   m_w_*   : W channel to memory
// Modport master is the sequencer's view; slave is the environment's view.
interface axi_write_sequencer_if #(
  parameter int unsigned NumPorts = 3,
  parameter int unsigned AwWidth  = 64,
  parameter int unsigned WWidth   = 73
);
  logic [NumPorts*AwWidth-1:0] s_aw_i;
  logic [NumPorts-1:0]         s_aw_valid_i;
  logic [NumPorts-1:0]         s_aw_ready_o;
  logic [NumPorts*WWidth-1:0]  s_w_i;
  logic [NumPorts-1:0]         s_w_last_i;
  logic [NumPorts-1:0]         s_w_valid_i;
  logic [NumPorts-1:0]         s_w_ready_o;
  logic [AwWidth-1:0]          m_aw_o;
  logic                        m_aw_valid_o;
  logic                        m_aw_ready_i;
  logic [WWidth-1:0]           m_w_o;
  logic                        m_w_last_o;
  logic                        m_w_valid_o;
  logic                        m_w_ready_i;

  modport master (
    input  s_aw_i, s_aw_valid_i, s_w_i, s_w_last_i, s_w_valid_i,
    output s_aw_ready_o, s_w_ready_o,
    output m_aw_o, m_aw_valid_o, m_w_o, m_w_last_o, m_w_valid_o,
    input  m_aw_ready_i, m_w_ready_i
  );

  modport slave (
    output s_aw_i, s_aw_valid_i, s_w_i, s_w_last_i, s_w_valid_i,
    input  s_aw_ready_o, s_w_ready_o,
    input  m_aw_o, m_aw_valid_o, m_w_o, m_w_last_o, m_w_valid_o,
    output m_aw_ready_i, m_w_ready_i
  );
endinterface

// File: rtl/axi_write_sequencer.sv
// Shares one AXI4 AW+W master port among NumPorts write requesters.
// AW is round-robin arbitrated with the grant locked until handshake; the
// order of accepted AWs is kept in a small FIFO whose head steers W, since
// AXI4 has no WID and write data must follow AW order.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : requester slave ports and memory master port
//   busy_o       : an AW is locked or some burst still owes W data
//   pending_o    : order-FIFO occupancy
module axi_write_sequencer #(
  parameter int unsigned NumPorts = 3,
  parameter int unsigned AwWidth  = 64,
  parameter int unsigned WWidth   = 73,
  parameter int unsigned Depth    = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  axi_write_sequencer_if.master      bus,
  output logic                       busy_o,
  output logic [$clog2(Depth+1)-1:0] pending_o
);

  localparam int unsigned IdxW = $clog2(NumPorts);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef enum logic {ST_ARB, ST_LOCK} aw_state_e;

  aw_state_e       state_q, state_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] lock_q, lock_d;
  logic [IdxW-1:0] arb_c, grant_c;
  logic            full_c, empty_c, push_c, pop_c;

  logic [IdxW-1:0] fifo_q [Depth];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [CntW-1:0] cnt_q;
  logic [IdxW-1:0] sel_c;

  assign full_c  = (cnt_q == CntW'(Depth));
  assign empty_c = (cnt_q == '0);
  assign sel_c   = fifo_q[rd_q];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Cyclic search for the first valid requester starting at rr_q.
  always_comb begin : p_arb
    int unsigned j;
    logic        found;
    arb_c = rr_q;
    found = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      j = 32'(rr_q) + i;
      if (j >= NumPorts) j = j - NumPorts;
      if (!found && bus.s_aw_valid_i[IdxW'(j)]) begin
        found = 1'b1;
        arb_c = IdxW'(j);
      end
    end
  end

  // AW next-state and outputs; everything is gated off during reset.
  always_comb begin
    state_d          = state_q;
    rr_d             = rr_q;
    lock_d           = lock_q;
    grant_c          = (state_q == ST_LOCK) ? lock_q : arb_c;
    bus.m_aw_valid_o = 1'b0;
    bus.m_aw_o       = '0;
    bus.s_aw_ready_o = '0;
    push_c           = 1'b0;

    for (int unsigned p = 0; p < NumPorts; p++) begin
      if (IdxW'(p) == grant_c) bus.m_aw_o = bus.s_aw_i[p*AwWidth +: AwWidth];
    end

    if (!rst_i && !full_c) begin
      bus.m_aw_valid_o = (state_q == ST_LOCK) ? bus.s_aw_valid_i[lock_q]
                                              : |bus.s_aw_valid_i;
    end
    push_c = bus.m_aw_valid_o & bus.m_aw_ready_i;
    if (push_c) begin
      bus.s_aw_ready_o[grant_c] = 1'b1;
      rr_d = (grant_c == IdxW'(NumPorts - 1)) ? '0 : grant_c + IdxW'(1);
    end

    unique case (state_q)
      ST_ARB: begin
        if (bus.m_aw_valid_o && !bus.m_aw_ready_i) begin
          state_d = ST_LOCK;
          lock_d  = grant_c;
        end
      end
      ST_LOCK: begin
        if (push_c) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
  end

  // W steering from the FIFO head; W with no accepted AW is stalled.
  always_comb begin
    bus.m_w_o        = '0;
    bus.m_w_last_o   = 1'b0;
    bus.m_w_valid_o  = 1'b0;
    bus.s_w_ready_o  = '0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      if (!rst_i && !empty_c && IdxW'(p) == sel_c) begin
        bus.m_w_o          = bus.s_w_i[p*WWidth +: WWidth];
        bus.m_w_last_o     = bus.s_w_last_i[p];
        bus.m_w_valid_o    = bus.s_w_valid_i[p];
        bus.s_w_ready_o[p] = bus.m_w_ready_i;
      end
    end
    pop_c = bus.m_w_valid_o & bus.m_w_ready_i & bus.m_w_last_o;
  end

  // Control state; reset discards any in-flight bursts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_ARB;
      rr_q    <= '0;
      lock_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      if (push_c) wr_q <= ptr_inc(wr_q);
      if (pop_c)  rd_q <= ptr_inc(rd_q);
      unique case ({push_c, pop_c})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Order storage needs no reset: entries are only read while counted.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_c) fifo_q[wr_q] <= grant_c;
  end

  assign busy_o    = (state_q == ST_LOCK) | ~empty_c;
  assign pending_o = cnt_q;

endmodule
